// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state and last-grant encodings.
// Latency: n/a.
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CPU  = 2'd1,
        ARB_DBG  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } arb_gnt_t;

    localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Access-cycle counter: walks 0..MEM_LAT-1 while enabled, flags the final cycle.
// Latency: last is combinational from the count.
// Backpressure: none; clear wins over enable.
module lat_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clock,
    input  logic reset_L,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CW-1:0] cnt;

    assign last = (cnt == CW'(MEM_LAT - 1));

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)    cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= last ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/register.sv
// Generic load-enabled register with active-low load and async active-low reset to zero.
// Latency: one cycle from load edge to Q.
// Backpressure: none; Q holds while load_L is high.
module register #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset_L,
    input  logic         load_L,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)     Q <= '0;
        else if (!load_L) Q <= D;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU datapath and a debug port, alternating on ties.
// Latency: 1 arbitration cycle + MEM_LAT access cycles; debug ack one cycle after that.
// Backpressure: CPU held via combinational cpu_stall; debug holds dbg_req until dbg_ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic          cpu_re_L,
    input  logic          cpu_we_L,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re_L,
    output logic          mem_we_L,
    input  logic [DW-1:0] mem_rdata
);

    localparam int RW = 1 + AW + DW;

    arb_state_t    state;
    arb_gnt_t      lastGnt;
    logic          cpuReq;
    logic          dbgReqEff;
    logic          gntCpu;
    logic          gntDbg;
    logic          grant;
    logic          cntLast;
    logic          accActive;
    logic [RW-1:0] reqD;
    logic [RW-1:0] reqQ;
    logic          reqWe;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqWdata;

    // Both CPU strobes low counts as a write.
    assign cpuReq = ~cpu_re_L | ~cpu_we_L;

    // The requester is still holding dbg_req during its ack cycle; that must not re-grant.
    assign dbgReqEff = dbg_req & ~dbg_ack;

    assign gntCpu = (state == ARB_IDLE) & cpuReq & (~dbgReqEff | (lastGnt == GNT_DBG));
    assign gntDbg = (state == ARB_IDLE) & dbgReqEff & (~cpuReq | (lastGnt == GNT_CPU));
    assign grant  = gntCpu | gntDbg;

    assign reqD = gntCpu ? {~cpu_we_L, cpu_addr, cpu_wdata}
                         : {dbg_we, dbg_addr, dbg_wdata};

    register #(.W(RW)) u_reqReg (
        .clock   (clock),
        .reset_L (reset_L),
        .load_L  (~grant),
        .D       (reqD),
        .Q       (reqQ)
    );

    assign {reqWe, reqAddr, reqWdata} = reqQ;

    assign accActive = (state != ARB_IDLE);

    lat_counter #(.MEM_LAT(MEM_LAT)) u_latCnt (
        .clock   (clock),
        .reset_L (reset_L),
        .clear   (~accActive),
        .enable  (accActive),
        .last    (cntLast)
    );

    assign mem_addr  = reqAddr;
    assign mem_wdata = reqWdata;
    assign mem_re_L  = ~(accActive & ~reqWe);
    assign mem_we_L  = ~(accActive & reqWe);

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpuReq & ~((state == ARB_CPU) & cntLast);

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= ARB_IDLE;
            lastGnt   <= GNT_DBG;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (gntCpu) begin
                        state   <= ARB_CPU;
                        lastGnt <= GNT_CPU;
                    end else if (gntDbg) begin
                        state   <= ARB_DBG;
                        lastGnt <= GNT_DBG;
                    end
                end
                ARB_CPU: begin
                    if (cntLast) state <= ARB_IDLE;
                end
                ARB_DBG: begin
                    if (cntLast) begin
                        state   <= ARB_IDLE;
                        dbg_ack <= 1'b1;
                        if (!reqWe) dbg_rdata <= mem_rdata;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    aBothStrobes: assert property (@(posedge clock) disable iff (!reset_L)
        !(~cpu_re_L & ~cpu_we_L))
        else $error("cpu_re_L and cpu_we_L both asserted");

    aCpuHeld: assert property (@(posedge clock) disable iff (!reset_L)
        (state == ARB_CPU) |-> cpuReq)
        else $error("CPU request dropped while granted");

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic        sel = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic        sCpuReL = 1'b1, sCpuWeL = 1'b1, sDbgReq = 1'b0, sDbgWe = 1'b0;
    logic [15:0] sCpuAddr = '0, sCpuWdata = '0, sDbgAddr = '0, sDbgWdata = '0;

    logic [15:0] d0CpuRdata, d0DbgRdata, d0MemAddr, d0MemWdata, d0MemRdata;
    logic        d0Stall, d0Ack, d0ReL, d0WeL;
    logic [15:0] d1CpuRdata, d1DbgRdata, d1MemAddr, d1MemWdata, d1MemRdata;
    logic        d1Stall, d1Ack, d1ReL, d1WeL;

    logic [15:0] oCpuRdata, oDbgRdata, oMemAddr, oMemWdata;
    logic        oStall, oAck, oReL, oWeL;

    always #5 clock = ~clock;

    function automatic logic [15:0] memVal(input logic [15:0] a);
        if (a == 16'h0040) return 16'hBEEF;
        if (a == 16'h0100) return 16'hCAFE;
        return a ^ 16'h5A5A;
    endfunction

    assign d0MemRdata = memVal(d0MemAddr);
    assign d1MemRdata = memVal(d1MemAddr);

    mem_port_arbiter #(.MEM_LAT(2), .AW(16), .DW(16)) u_dut (
        .clock(clock), .reset_L(reset_L),
        .cpu_re_L(sel ? 1'b1 : sCpuReL), .cpu_we_L(sel ? 1'b1 : sCpuWeL),
        .cpu_addr(sCpuAddr), .cpu_wdata(sCpuWdata),
        .cpu_rdata(d0CpuRdata), .cpu_stall(d0Stall),
        .dbg_req(sel ? 1'b0 : sDbgReq), .dbg_we(sDbgWe),
        .dbg_addr(sDbgAddr), .dbg_wdata(sDbgWdata),
        .dbg_rdata(d0DbgRdata), .dbg_ack(d0Ack),
        .mem_addr(d0MemAddr), .mem_wdata(d0MemWdata),
        .mem_re_L(d0ReL), .mem_we_L(d0WeL), .mem_rdata(d0MemRdata)
    );

    mem_port_arbiter #(.MEM_LAT(1), .AW(16), .DW(16)) u_dutLat1 (
        .clock(clock), .reset_L(reset_L),
        .cpu_re_L(sel ? sCpuReL : 1'b1), .cpu_we_L(sel ? sCpuWeL : 1'b1),
        .cpu_addr(sCpuAddr), .cpu_wdata(sCpuWdata),
        .cpu_rdata(d1CpuRdata), .cpu_stall(d1Stall),
        .dbg_req(sel ? sDbgReq : 1'b0), .dbg_we(sDbgWe),
        .dbg_addr(sDbgAddr), .dbg_wdata(sDbgWdata),
        .dbg_rdata(d1DbgRdata), .dbg_ack(d1Ack),
        .mem_addr(d1MemAddr), .mem_wdata(d1MemWdata),
        .mem_re_L(d1ReL), .mem_we_L(d1WeL), .mem_rdata(d1MemRdata)
    );

    assign oCpuRdata = sel ? d1CpuRdata : d0CpuRdata;
    assign oDbgRdata = sel ? d1DbgRdata : d0DbgRdata;
    assign oMemAddr  = sel ? d1MemAddr  : d0MemAddr;
    assign oMemWdata = sel ? d1MemWdata : d0MemWdata;
    assign oStall    = sel ? d1Stall    : d0Stall;
    assign oAck      = sel ? d1Ack      : d0Ack;
    assign oReL      = sel ? d1ReL      : d0ReL;
    assign oWeL      = sel ? d1WeL      : d0WeL;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_L = 1'b0;
        sCpuReL = 1'b1; sCpuWeL = 1'b1; sDbgReq = 1'b0;
        #1;
        chk("rst_stall", oStall, 0);
        chk("rst_re", oReL, 1);
        chk("rst_we", oWeL, 1);
        chk("rst_addr", oMemAddr, 0);
        chk("rst_wdata", oMemWdata, 0);
        chk("rst_dbg_rdata", oDbgRdata, 0);
        chk("rst_ack", oAck, 0);
        @(negedge clock);
        reset_L = 1'b1;
    endtask

    task automatic cpuAccess(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] expRd, input int lat);
        step();
        sCpuAddr = addr; sCpuWdata = wdata;
        if (we) sCpuWeL = 1'b0; else sCpuReL = 1'b0;
        @(negedge clock);
        chk("cpu_arb_stall", oStall, 1);
        chk("cpu_arb_strobes", {oReL, oWeL}, 2'b11);
        for (int i = 1; i <= lat; i++) begin
            step();
            @(negedge clock);
            chk("cpu_acc_stall", oStall, (i == lat) ? 0 : 1);
            chk("cpu_acc_strobes", {oReL, oWeL}, we ? 2'b10 : 2'b01);
            chk("cpu_acc_addr", oMemAddr, addr);
            if (we) chk("cpu_acc_wdata", oMemWdata, wdata);
            else if (i == lat) chk("cpu_rdata", oCpuRdata, expRd);
        end
        step();
        sCpuReL = 1'b1; sCpuWeL = 1'b1;
        @(negedge clock);
        chk("cpu_done_strobes", {oReL, oWeL}, 2'b11);
        chk("cpu_done_stall", oStall, 0);
    endtask

    task automatic dbgAccess(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             input logic [15:0] expRd, input int lat);
        step();
        sDbgReq = 1'b1; sDbgWe = we; sDbgAddr = addr; sDbgWdata = wdata;
        @(negedge clock);
        chk("dbg_arb_strobes", {oReL, oWeL}, 2'b11);
        for (int i = 1; i <= lat; i++) begin
            step();
            // Requester inputs wander mid-access; the latched request must win.
            sDbgAddr = addr + 16'd7; sDbgWdata = ~wdata;
            @(negedge clock);
            chk("dbg_acc_strobes", {oReL, oWeL}, we ? 2'b10 : 2'b01);
            chk("dbg_acc_addr", oMemAddr, addr);
            if (we) chk("dbg_acc_wdata", oMemWdata, wdata);
            chk("dbg_acc_ack", oAck, 0);
        end
        step();
        @(negedge clock);
        chk("dbg_ack_pulse", oAck, 1);
        chk("dbg_rdata", oDbgRdata, expRd);
        chk("dbg_ack_idle", {oReL, oWeL}, 2'b11);
        sDbgReq = 1'b0;
        step();
        @(negedge clock);
        chk("dbg_ack_once", oAck, 0);
        chk("dbg_rdata_hold", oDbgRdata, expRd);
        chk("dbg_no_regrant", {oReL, oWeL}, 2'b11);
    endtask

    task automatic tieRound(input bit cpuFirst, input int lat);
        bit cpuDone = 1'b0;
        step();
        sCpuReL = 1'b0; sCpuWeL = 1'b1; sCpuAddr = 16'h0200;
        sDbgReq = 1'b1; sDbgWe = 1'b0; sDbgAddr = 16'h0300;
        @(negedge clock);
        chk("tie_arb_strobes", {oReL, oWeL}, 2'b11);
        for (int p = 0; p < 2; p++) begin
            bit isCpu = ((p == 0) == cpuFirst);
            for (int i = 1; i <= lat; i++) begin
                step();
                @(negedge clock);
                chk(isCpu ? "tie_cpu_addr" : "tie_dbg_addr", oMemAddr, isCpu ? 16'h0200 : 16'h0300);
                chk("tie_acc_re", oReL, 0);
                chk("tie_acc_stall", oStall, isCpu ? ((i == lat) ? 0 : 1) : (cpuDone ? 0 : 1));
            end
            step();
            if (isCpu) begin
                sCpuReL = 1'b1;
                cpuDone = 1'b1;
                @(negedge clock);
                chk("tie_cpu_after", oAck, 0);
            end else begin
                @(negedge clock);
                chk("tie_dbg_ack", oAck, 1);
                chk("tie_dbg_rdata", oDbgRdata, memVal(16'h0300));
                sDbgReq = 1'b0;
            end
            chk("tie_idle_strobes", {oReL, oWeL}, 2'b11);
        end
    endtask

    initial begin
        doReset();

        cpuAccess(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2);
        cpuAccess(1'b1, 16'h0041, 16'h1234, 16'h0000, 2);
        dbgAccess(1'b0, 16'h0100, 16'h0000, 16'hCAFE, 2);
        dbgAccess(1'b1, 16'h0101, 16'h5555, 16'hCAFE, 2);

        // CPU was granted last, so a tie now goes to debug first.
        cpuAccess(1'b0, 16'h0042, 16'h0000, memVal(16'h0042), 2);
        tieRound(1'b0, 2);

        doReset();
        tieRound(1'b1, 2);
        tieRound(1'b1, 2);

        // Reset while the CPU access is in its first memory cycle.
        doReset();
        step();
        sCpuReL = 1'b0; sCpuAddr = 16'h0044;
        step();
        @(negedge clock);
        chk("pre_rst_re", oReL, 0);
        reset_L = 1'b0;
        #1;
        chk("midrst_re", oReL, 1);
        chk("midrst_we", oWeL, 1);
        chk("midrst_ack", oAck, 0);
        chk("midrst_stall", oStall, 1);
        sCpuReL = 1'b1;
        @(negedge clock);
        reset_L = 1'b1;
        step();
        @(negedge clock);
        chk("post_rst_re", oReL, 1);

        sel = 1'b1;
        doReset();
        tieRound(1'b1, 1);
        tieRound(1'b1, 1);
        cpuAccess(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 1);
        dbgAccess(1'b0, 16'h0100, 16'h0000, 16'hCAFE, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
